arith_op_initiator: RTL and testbench
=====================================

Name: arith_op_initiator

Overview:
- Sequential initiator for the combinational signed ALU (add/sub/and/or, NB_DATA-wide, NB_SEL-wide select).
- Accepts commands on a valid/ready front end and drives registered operands and select into the ALU.
- Captures the ALU result one cycle later and returns it on a valid/ready response port with status flags.
- Sits between the control/testbench sequencer and the ALU instance. It is the requesting end of the ALU's operand/result interface.

Parameters:
- NB_DATA, 16, data width of operands and result (two's complement).
- NB_SEL, 2, opcode width. Encoding: 0 = ADD, 1 = SUB, 2 = AND, 3 = OR.
- NB_CNT, 8, width of the completed-operation counter.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  reset; asynchronous, active-high.
- i_cmd_valid  input  1  command valid.
- o_cmd_ready  output  1  command ready; high only in IDLE.
- i_cmd_a  input  NB_DATA  operand A, signed.
- i_cmd_b  input  NB_DATA  operand B, signed.
- i_cmd_sel  input  NB_SEL  opcode.
- o_alu_a  output  NB_DATA  registered operand A to ALU.
- o_alu_b  output  NB_DATA  registered operand B to ALU.
- o_alu_sel  output  NB_SEL  registered opcode to ALU.
- i_alu_c  input  NB_DATA  ALU result, combinational from o_alu_*.
- o_rsp_valid  output  1  response valid.
- i_rsp_ready  input  1  response ready.
- o_rsp_data  output  NB_DATA  captured result.
- o_rsp_sel  output  NB_SEL  opcode that produced o_rsp_data.
- o_rsp_zero  output  1  result == 0.
- o_rsp_neg  output  1  result MSB.
- o_rsp_ovf  output  1  signed overflow; ADD/SUB only.
- o_op_count  output  NB_CNT  count of completed response handshakes.

Behaviour:
- Reset (async, i_rst = 1): state = IDLE; every output register = 0 (o_alu_*, o_rsp_*, o_op_count). o_cmd_ready = 1 after reset deasserts. Reset mid-operation aborts the operation; no response is produced.
- States: IDLE, EXEC, RESP.
- IDLE: o_cmd_ready = 1. On i_cmd_valid & o_cmd_ready at edge N:
  - latch i_cmd_a/b/sel into o_alu_a/b/sel;
  - go to EXEC.
- EXEC, one cycle, o_cmd_ready = 0. At edge N+1:
  - register i_alu_c into o_rsp_data; o_alu_sel into o_rsp_sel;
  - compute flags from o_alu_a, o_alu_b and i_alu_c;
  - set o_rsp_valid = 1; go to RESP.
- RESP: o_rsp_valid = 1 and all o_rsp_* held stable until i_rsp_ready = 1.
  - On handshake at an edge: o_rsp_valid -> 0, o_op_count += 1 (wraps 2^NB_CNT - 1 -> 0), go to IDLE.
- Latency and throughput:
  - o_rsp_valid first high in the cycle after edge N+1 (2 cycles after command acceptance).
  - Best-case throughput: one command per 3 cycles.
  - No command accepted while in EXEC or RESP. A command and a response handshake in the same cycle is impossible.
- o_alu_a/b/sel hold their last values outside EXEC; no return to 0 after use.
- i_cmd_valid is ignored when not in IDLE. A command with i_cmd_valid low is never latched.
- Flags:
  - zero = (result == 0).
  - neg = result[NB_DATA-1].
  - ovf for ADD = (a[MSB] == b[MSB]) & (c[MSB] != a[MSB]).
  - ovf for SUB = (a[MSB] != b[MSB]) & (c[MSB] != a[MSB]).
  - ovf for AND/OR = 0.
- Arithmetic wraps modulo 2^NB_DATA (ALU behaviour); this block does no widening.
- Undefined opcodes do not exist (the encoding is full). Flags follow the rules above for all 4 opcodes.

Test Plan (NB_DATA = 16 unless noted):
- Add overflow: cmd A = 0x7FFF, B = 0x0001, sel = 0, i_rsp_ready = 1 -> o_rsp_valid 2 cycles after accept; data = 0x8000, neg = 1, ovf = 1, zero = 0, o_op_count = 1.
- Sub zero: A = 0x0005, B = 0x0005, sel = 1 -> data = 0x0000, zero = 1, neg = 0, ovf = 0. Then A = 0x8000, B = 0x0001, sel = 1 -> data = 0x7FFF, ovf = 1.
- Logic ops: AND 0xF0F0 & 0x0FF0 -> 0x00F0, ovf = 0. OR 0xF000 | 0x000F -> 0xF00F, neg = 1, ovf = 0. o_rsp_sel matches the command opcode each time.
- Backpressure: hold i_rsp_ready = 0 for 5 cycles in RESP, toggling i_cmd_valid with new operands -> o_rsp_* stable, o_cmd_ready = 0, new operands not latched. Release -> back to IDLE the next cycle, count += 1.
- Reset mid-operation: assert i_rst asynchronously while in EXEC -> all outputs 0 immediately. After release: o_cmd_ready = 1, no spurious o_rsp_valid, o_op_count = 0.
- Counter wrap (NB_CNT = 4): complete 16 back-to-back operations with i_cmd_valid/i_rsp_ready held high -> o_op_count returns to 0. Accept-to-accept spacing is exactly 3 cycles.

Source files
------------

// File: rtl/arith_op_initiator.sv
// Sequential initiator for a combinational signed ALU: accepts one command,
// drives registered operands, captures the result and returns it with status flags.
module arith_op_initiator #(
    parameter int NB_DATA = 16,
    parameter int NB_SEL  = 2,
    parameter int NB_CNT  = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    // command front end
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [NB_DATA-1:0] i_cmd_a,
    input  logic [NB_DATA-1:0] i_cmd_b,
    input  logic [NB_SEL-1:0]  i_cmd_sel,
    // ALU operand/result interface
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_SEL-1:0]  o_alu_sel,
    input  logic [NB_DATA-1:0] i_alu_c,
    // response back end
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [NB_DATA-1:0] o_rsp_data,
    output logic [NB_SEL-1:0]  o_rsp_sel,
    output logic               o_rsp_zero,
    output logic               o_rsp_neg,
    output logic               o_rsp_ovf,
    output logic [NB_CNT-1:0]  o_op_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [NB_SEL-1:0] SEL_ADD = NB_SEL'(0);
    localparam logic [NB_SEL-1:0] SEL_SUB = NB_SEL'(1);

    state_t               state_q, state_d;
    logic [NB_DATA-1:0]   alu_a_q, alu_a_d;
    logic [NB_DATA-1:0]   alu_b_q, alu_b_d;
    logic [NB_SEL-1:0]    alu_sel_q, alu_sel_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [NB_DATA-1:0]   rsp_data_q, rsp_data_d;
    logic [NB_SEL-1:0]    rsp_sel_q, rsp_sel_d;
    logic                 rsp_zero_q, rsp_zero_d;
    logic                 rsp_neg_q, rsp_neg_d;
    logic                 rsp_ovf_q, rsp_ovf_d;
    logic [NB_CNT-1:0]    count_q, count_d;

    logic                 a_msb, b_msb, c_msb;
    logic                 ovf_now;
    logic                 cmd_ready;

    assign a_msb = alu_a_q[NB_DATA-1];
    assign b_msb = alu_b_q[NB_DATA-1];
    assign c_msb = i_alu_c[NB_DATA-1];

    // Signed overflow from operand/result sign bits; logic ops never overflow.
    always_comb begin
        ovf_now = 1'b0;
        case (alu_sel_q)
            SEL_ADD: ovf_now = (a_msb == b_msb) && (c_msb != a_msb);
            SEL_SUB: ovf_now = (a_msb != b_msb) && (c_msb != a_msb);
            default: ovf_now = 1'b0;
        endcase
    end

    // Ready is withheld while reset is asserted so nothing is offered mid-reset.
    assign cmd_ready = (state_q == ST_IDLE) && !i_rst;

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_sel_d   = rsp_sel_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_neg_d   = rsp_neg_q;
        rsp_ovf_d   = rsp_ovf_q;
        count_d     = count_q;

        case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    alu_a_d   = i_cmd_a;
                    alu_b_d   = i_cmd_b;
                    alu_sel_d = i_cmd_sel;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d  = i_alu_c;
                rsp_sel_d   = alu_sel_q;
                rsp_zero_d  = (i_alu_c == '0);
                rsp_neg_d   = c_msb;
                rsp_ovf_d   = ovf_now;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    count_d     = count_q + NB_CNT'(1);
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_sel_q   <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_neg_q   <= 1'b0;
            rsp_ovf_q   <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_sel_q   <= rsp_sel_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_neg_q   <= rsp_neg_d;
            rsp_ovf_q   <= rsp_ovf_d;
            count_q     <= count_d;
        end
    end

    assign o_cmd_ready = cmd_ready;
    assign o_alu_a     = alu_a_q;
    assign o_alu_b     = alu_b_q;
    assign o_alu_sel   = alu_sel_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_sel   = rsp_sel_q;
    assign o_rsp_zero  = rsp_zero_q;
    assign o_rsp_neg   = rsp_neg_q;
    assign o_rsp_ovf   = rsp_ovf_q;
    assign o_op_count  = count_q;

endmodule

// File: tb/tb_arith_op_initiator.sv
// Self-checking bench for arith_op_initiator: directed vector table, random
// operations against an integer-arithmetic reference, and multi-cycle corner cases.
module tb_arith_op_initiator;

    localparam int NB_DATA = 16;
    localparam int NB_SEL  = 2;
    localparam int NB_CNT  = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [NB_DATA-1:0] cmd_a, cmd_b;
    logic [NB_SEL-1:0]  cmd_sel;
    logic [NB_DATA-1:0] alu_a, alu_b, alu_c;
    logic [NB_SEL-1:0]  alu_sel;
    logic               rsp_valid, rsp_ready;
    logic [NB_DATA-1:0] rsp_data;
    logic [NB_SEL-1:0]  rsp_sel;
    logic               rsp_zero, rsp_neg, rsp_ovf;
    logic [NB_CNT-1:0]  op_count;

    int total = 0;
    int bad   = 0;
    logic [NB_CNT-1:0] exp_cnt = '0;

    always #5 clk = ~clk;

    arith_op_initiator #(.NB_DATA(NB_DATA), .NB_SEL(NB_SEL), .NB_CNT(NB_CNT)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_a(cmd_a), .i_cmd_b(cmd_b), .i_cmd_sel(cmd_sel),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_sel(alu_sel), .i_alu_c(alu_c),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_data(rsp_data), .o_rsp_sel(rsp_sel),
        .o_rsp_zero(rsp_zero), .o_rsp_neg(rsp_neg), .o_rsp_ovf(rsp_ovf),
        .o_op_count(op_count)
    );

    // Combinational ALU the initiator talks to.
    always_comb begin
        case (alu_sel)
            2'd0:    alu_c = alu_a + alu_b;
            2'd1:    alu_c = alu_a - alu_b;
            2'd2:    alu_c = alu_a & alu_b;
            default: alu_c = alu_a | alu_b;
        endcase
    end

    typedef struct {
        logic [NB_DATA-1:0] a;
        logic [NB_DATA-1:0] b;
        logic [NB_SEL-1:0]  sel;
        logic [NB_DATA-1:0] data;
        logic               zero;
        logic               neg;
        logic               ovf;
    } vec_t;

    // Reference: exact integer result, overflow when it leaves the signed range.
    function automatic vec_t ref_model(input logic [NB_DATA-1:0] a,
                                       input logic [NB_DATA-1:0] b,
                                       input logic [NB_SEL-1:0] sel);
        vec_t v;
        int sa, sb, r;
        logic [31:0] rv;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (sel)
            2'd0:    r = sa + sb;
            2'd1:    r = sa - sb;
            2'd2:    r = int'($signed(a & b));
            default: r = int'($signed(a | b));
        endcase
        rv = r;
        v.a = a; v.b = b; v.sel = sel;
        v.data = rv[NB_DATA-1:0];
        v.zero = (v.data == 0);
        v.neg  = (r < 0) ? 1'b1 : (sel >= 2'd2 ? v.data[NB_DATA-1] : 1'b0);
        if (sel < 2'd2) v.neg = v.data[NB_DATA-1];
        v.ovf  = (sel < 2'd2) && (r > 32767 || r < -32768);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    // Called at posedge+1 with the DUT idle; runs one full command/response.
    task automatic run_op(input vec_t v, input string nm);
        cmd_a = v.a; cmd_b = v.b; cmd_sel = v.sel; cmd_valid = 1'b1;
        chk({nm, ".ready_idle"}, 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk({nm, ".alu_a"}, 32'(alu_a), 32'(v.a));
        chk({nm, ".alu_b"}, 32'(alu_b), 32'(v.b));
        chk({nm, ".alu_sel"}, 32'(alu_sel), 32'(v.sel));
        chk({nm, ".ready_exec"}, 32'(cmd_ready), 32'd0);
        chk({nm, ".valid_early"}, 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk({nm, ".valid"}, 32'(rsp_valid), 32'd1);
        chk({nm, ".data"}, 32'(rsp_data), 32'(v.data));
        chk({nm, ".sel"}, 32'(rsp_sel), 32'(v.sel));
        chk({nm, ".flags"}, {29'd0, rsp_zero, rsp_neg, rsp_ovf}, {29'd0, v.zero, v.neg, v.ovf});
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_cnt = exp_cnt + 1'b1;
        chk({nm, ".valid_drop"}, 32'(rsp_valid), 32'd0);
        chk({nm, ".count"}, 32'(op_count), 32'(exp_cnt));
        $display("op %s a=%h b=%h sel=%0d -> data=%h z=%b n=%b o=%b cnt=%0d",
                 nm, v.a, v.b, v.sel, rsp_data, rsp_zero, rsp_neg, rsp_ovf, op_count);
    endtask

    vec_t tbl[6];
    vec_t v;
    logic [NB_DATA-1:0] hold_data, hold_a;
    int acc_cyc[$];

    initial begin
        tbl[0] = '{16'h7FFF, 16'h0001, 2'd0, 16'h8000, 1'b0, 1'b1, 1'b1};
        tbl[1] = '{16'h0005, 16'h0005, 2'd1, 16'h0000, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{16'h8000, 16'h0001, 2'd1, 16'h7FFF, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{16'hF0F0, 16'h0FF0, 2'd2, 16'h00F0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{16'hF000, 16'h000F, 2'd3, 16'hF00F, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{16'h8000, 16'h8000, 2'd0, 16'h0000, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.outs", {alu_a, alu_b}, 32'd0);
        chk("reset.rsp", {13'd0, rsp_valid, rsp_data, rsp_zero, rsp_neg, rsp_ovf},  32'd0);
        chk("reset.count", 32'(op_count), 32'd0);
        rst = 1'b0;
        #1;
        chk("reset.ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_op(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 30; i++) begin
            v = ref_model(16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
            run_op(v, $sformatf("rnd%0d", i));
        end

        // Backpressure: response held, commands ignored.
        cmd_a = 16'h1234; cmd_b = 16'h4321; cmd_sel = 2'd0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        hold_data = rsp_data; hold_a = alu_a;
        chk("bp.data", 32'(hold_data), 32'h5555);
        for (int i = 0; i < 5; i++) begin
            cmd_valid = ~cmd_valid; cmd_a = 16'($urandom); cmd_b = 16'($urandom);
            @(posedge clk); #1;
            chk("bp.valid", 32'(rsp_valid), 32'd1);
            chk("bp.stable", 32'(rsp_data), 32'(hold_data));
            chk("bp.ready", 32'(cmd_ready), 32'd0);
            chk("bp.alu_a", 32'(alu_a), 32'(hold_a));
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0; exp_cnt = exp_cnt + 1'b1;
        chk("bp.release_valid", 32'(rsp_valid), 32'd0);
        chk("bp.release_ready", 32'(cmd_ready), 32'd1);
        chk("bp.count", 32'(op_count), 32'(exp_cnt));
        $display("op backpressure data=%h cnt=%0d", hold_data, op_count);

        // Reset while in EXEC.
        cmd_a = 16'h7FFF; cmd_b = 16'h7FFF; cmd_sel = 2'd0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_mid.alu", {alu_a, alu_b}, 32'd0);
        chk("rst_mid.sel", {28'd0, alu_sel, rsp_sel}, 32'd0);
        chk("rst_mid.rsp", {13'd0, rsp_valid, rsp_data, rsp_zero, rsp_neg, rsp_ovf}, 32'd0);
        chk("rst_mid.count", 32'(op_count), 32'd0);
        chk("rst_mid.ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; exp_cnt = '0;
        #1;
        chk("rst_after.ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_after.valid", 32'(rsp_valid), 32'd0);
            chk("rst_after.count", 32'(op_count), 32'd0);
        end
        $display("op reset_mid cnt=%0d ready=%b", op_count, cmd_ready);

        // Back-to-back: 16 operations with valid/ready held high, counter wraps.
        cmd_a = 16'h0003; cmd_b = 16'h0004; cmd_sel = 2'd0;
        cmd_valid = 1'b1; rsp_ready = 1'b1;
        for (int c = 0; c < 48; c++) begin
            if (cmd_ready) acc_cyc.push_back(c);
            if (c == 45) chk("wrap.count15", 32'(op_count), 32'd15);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        chk("wrap.accepts", 32'(acc_cyc.size()), 32'd16);
        for (int i = 1; i < acc_cyc.size(); i++)
            chk("wrap.spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
        chk("wrap.count", 32'(op_count), 32'd0);
        chk("wrap.data", 32'(rsp_data), 32'h0007);
        $display("op wrap accepts=%0d cnt=%0d", acc_cyc.size(), op_count);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
